// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM command scheduler.
package dram_pkg;

   localparam int REFI_CYCLES_DEFAULT = 1560;
   localparam int PEND_BITS           = 4;
   localparam logic [PEND_BITS-1:0] PEND_MAX = 4'd8;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      IDLE    = 2'd1,
      BUSY    = 2'd2,
      REFRESH = 2'd3
   } sched_state_t;

   typedef enum logic [1:0] {
      ROW_CLOSED   = 2'd0,
      ROW_HIT      = 2'd1,
      ROW_CONFLICT = 2'd2
   } row_stat_t;

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval down-counter with a saturating count of refreshes owed.
module refresh_timer
   import dram_pkg::*;
#(
   parameter int REFI_CYCLES = REFI_CYCLES_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 en,
   input  logic                 dec,
   output logic [PEND_BITS-1:0] pending
);

   localparam int TW = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(REFI_CYCLES - 1);

   logic [TW-1:0] timer;
   logic          due;

   assign due = en && (timer == '0);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         timer <= RELOAD;
      end else if (en) begin
         timer <= due ? RELOAD : timer - TW'(1);
      end
   end

   // Simultaneous due and service cancel out.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         pending <= '0;
      end else if (due && !dec) begin
         if (pending != PEND_MAX) pending <= pending + PEND_BITS'(1);
      end else if (dec && !due) begin
         if (pending != '0) pending <= pending - PEND_BITS'(1);
      end
   end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Two-requester DRAM command scheduler with refresh priority and open-row tracking.
//   state   | meaning
//   INIT    | waiting for device init_done, everything quiet
//   IDLE    | pick refresh (if owed) or round-robin grant a request
//   BUSY    | drive dREN/dWEN for the latched access until ram_wait drops
//   REFRESH | hold rf_req until tREF_done, then close all banks
module dram_cmd_scheduler
   import dram_pkg::*;
#(
   parameter int REFI_CYCLES = REFI_CYCLES_DEFAULT,
   parameter int ROW_BITS    = 15,
   parameter int BANK_BITS   = 2
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 req0_valid,
   input  logic                 req0_we,
   input  logic [BANK_BITS-1:0] req0_bank,
   input  logic [ROW_BITS-1:0]  req0_row,
   output logic                 req0_ack,
   input  logic                 req1_valid,
   input  logic                 req1_we,
   input  logic [BANK_BITS-1:0] req1_bank,
   input  logic [ROW_BITS-1:0]  req1_row,
   output logic                 req1_ack,
   input  logic                 init_done,
   input  logic                 ram_wait,
   input  logic                 tREF_done,
   output logic                 dREN,
   output logic                 dWEN,
   output logic                 rf_req,
   output row_stat_t            row_stat,
   output logic [BANK_BITS-1:0] sel_bank,
   output logic [ROW_BITS-1:0]  sel_row
);

   localparam int NBANKS = 2 ** BANK_BITS;

   sched_state_t         state, state_nxt;
   logic [PEND_BITS-1:0] pending;
   logic                 any_req, grant, gnt_sel, complete, rf_dec;
   logic                 we_l, gnt_l, last_gnt;
   logic [BANK_BITS-1:0] bank_l;
   logic [ROW_BITS-1:0]  row_l;
   logic [NBANKS-1:0]    open_vld;
   logic [ROW_BITS-1:0]  open_row [NBANKS];

   refresh_timer #(.REFI_CYCLES(REFI_CYCLES)) u_rt (
      .CLK     (CLK),
      .nRST    (nRST),
      .en      (state != INIT),
      .dec     (rf_dec),
      .pending (pending)
   );

   assign any_req  = req0_valid | req1_valid;
   // With both valid, hand the grant to whoever did not win last time.
   assign gnt_sel  = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
   assign grant    = (state == IDLE) && (pending == '0) && any_req;
   assign complete = (state == BUSY) && !ram_wait;
   assign rf_dec   = (state == REFRESH) && tREF_done;

   always_ff @(posedge CLK) begin
      if (!nRST) state <= INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (init_done) state_nxt = IDLE;
         IDLE: begin
            if (pending != '0)  state_nxt = REFRESH;
            else if (any_req)   state_nxt = BUSY;
         end
         BUSY:    if (!ram_wait) state_nxt = IDLE;
         REFRESH: if (tREF_done) state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         we_l     <= 1'b0;
         gnt_l    <= 1'b0;
         last_gnt <= 1'b1;
         bank_l   <= '0;
         row_l    <= '0;
      end else if (grant) begin
         gnt_l    <= gnt_sel;
         last_gnt <= gnt_sel;
         we_l     <= gnt_sel ? req1_we   : req0_we;
         bank_l   <= gnt_sel ? req1_bank : req0_bank;
         row_l    <= gnt_sel ? req1_row  : req0_row;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         open_vld <= '0;
         for (int b = 0; b < NBANKS; b++) open_row[b] <= '0;
      end else if (rf_dec) begin
         open_vld <= '0;
      end else if (complete) begin
         open_vld[bank_l] <= 1'b1;
         open_row[bank_l] <= row_l;
      end
   end

   always_comb begin
      dREN     = 1'b0;
      dWEN     = 1'b0;
      rf_req   = 1'b0;
      row_stat = ROW_CLOSED;
      sel_bank = '0;
      sel_row  = '0;
      req0_ack = 1'b0;
      req1_ack = 1'b0;
      case (state)
         BUSY: begin
            dREN     = ~we_l;
            dWEN     = we_l;
            sel_bank = bank_l;
            sel_row  = row_l;
            if (!open_vld[bank_l])             row_stat = ROW_CLOSED;
            else if (open_row[bank_l] == row_l) row_stat = ROW_HIT;
            else                                row_stat = ROW_CONFLICT;
            // A reset landing on the completion cycle abandons the access.
            if (!ram_wait && nRST) begin
               req0_ack = ~gnt_l;
               req1_ack = gnt_l;
            end
         end
         REFRESH: rf_req = 1'b1;
         default: ;
      endcase
   end

endmodule
